// File: rtl/clock_pkg.sv
// ============================================================================
//  Module   : clock_pkg
//  Brief    : Shared types, digit positions, range limits and field widths
//             for the 24-hour clock load/display path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam int IDX_W = 3;

    // Digit order on the wire: HH MM SS, most significant digit first.
    localparam logic [IDX_W-1:0] IDX_HT = 3'd0;
    localparam logic [IDX_W-1:0] IDX_HO = 3'd1;
    localparam logic [IDX_W-1:0] IDX_MT = 3'd2;
    localparam logic [IDX_W-1:0] IDX_MO = 3'd3;
    localparam logic [IDX_W-1:0] IDX_ST = 3'd4;
    localparam logic [IDX_W-1:0] IDX_SO = 3'd5;

    localparam logic [3:0] HOUR_TENS_MAX       = 4'd2;
    localparam logic [3:0] HOUR_ONES_MAX_AT_20 = 4'd3;
    localparam logic [3:0] MS_TENS_MAX         = 4'd5;
    localparam logic [3:0] ONES_MAX            = 4'd9;

    // Field widths, matching the cnt24/cnt60 counter presets.
    localparam int HT_W = 2;
    localparam int HO_W = 4;
    localparam int MT_W = 3;
    localparam int MO_W = 4;
    localparam int ST_W = 3;
    localparam int SO_W = 4;

endpackage

`default_nettype wire

// File: rtl/time_loader_if.sv
// ============================================================================
//  Module   : time_loader_if
//  Brief    : Digit stream handshake plus time-field/status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface time_loader_if;
    import clock_pkg::*;

    logic            digit_valid;
    logic [3:0]      digit;
    logic            digit_ready;
    logic            abort;
    logic            load;
    logic [HT_W-1:0] hour_tens;
    logic [HO_W-1:0] hour_ones;
    logic [MT_W-1:0] min_tens;
    logic [MO_W-1:0] min_ones;
    logic [ST_W-1:0] sec_tens;
    logic [SO_W-1:0] sec_ones;
    logic            busy;
    logic            err;

    modport master (
        output digit_valid, digit, abort,
        input  digit_ready, load, hour_tens, hour_ones, min_tens, min_ones,
               sec_tens, sec_ones, busy, err
    );

    modport slave (
        input  digit_valid, digit, abort,
        output digit_ready, load, hour_tens, hour_ones, min_tens, min_ones,
               sec_tens, sec_ones, busy, err
    );

endinterface

`default_nettype wire

// File: rtl/digit_range_chk.sv
// ============================================================================
//  Module   : digit_range_chk
//  Brief    : Combinational legality check of one BCD digit at its position.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_range_chk
    import clock_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       digit,
    input  logic [HT_W-1:0]  hour_tens,
    output logic             ok
);

    always_comb begin
        ok = 1'b0;
        case (idx)
            IDX_HT: ok = (digit <= HOUR_TENS_MAX);
            // Hours 20..23 only: ones digit is capped once tens is 2.
            IDX_HO: ok = ({2'b00, hour_tens} == HOUR_TENS_MAX) ?
                         (digit <= HOUR_ONES_MAX_AT_20) : (digit <= ONES_MAX);
            IDX_MT: ok = (digit <= MS_TENS_MAX);
            IDX_MO: ok = (digit <= ONES_MAX);
            IDX_ST: ok = (digit <= MS_TENS_MAX);
            IDX_SO: ok = (digit <= ONES_MAX);
            default: ok = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/time_loader.sv
// ============================================================================
//  Module   : time_loader
//  Brief    : Collects six BCD digits (HHMMSS) and strobes a validated time
//             preset for the clock counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_loader
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    time_loader_if.slave bus
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic              r_load, w_load_nxt;
    logic              r_err, w_err_nxt;
    logic              w_ready, w_accept, w_ok, w_shadow_we;

    logic [HT_W-1:0]   r_sh_ht;
    logic [HO_W-1:0]   r_sh_ho;
    logic [MT_W-1:0]   r_sh_mt;
    logic [MO_W-1:0]   r_sh_mo;
    logic [ST_W-1:0]   r_sh_st;

    logic [HT_W-1:0]   r_hour_tens;
    logic [HO_W-1:0]   r_hour_ones;
    logic [MT_W-1:0]   r_min_tens;
    logic [MO_W-1:0]   r_min_ones;
    logic [ST_W-1:0]   r_sec_tens;
    logic [SO_W-1:0]   r_sec_ones;

    assign w_ready  = (r_state != LOAD) && !bus.abort;
    assign w_accept = bus.digit_valid && w_ready;

    digit_range_chk u_chk (
        .idx       (r_idx),
        .digit     (bus.digit),
        .hour_tens (r_sh_ht),
        .ok        (w_ok)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmo_nxt   = '0;
        w_load_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_shadow_we = 1'b0;
        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (w_accept) begin
                    if (w_ok) begin
                        w_shadow_we = 1'b1;
                        w_idx_nxt   = IDX_W'(1);
                        w_state_nxt = COLLECT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else if (w_accept) begin
                    if (!w_ok) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end else if (r_idx == IDX_SO) begin
                        // Last digit bypasses the shadow straight into the outputs.
                        w_load_nxt  = 1'b1;
                        w_state_nxt = LOAD;
                        w_idx_nxt   = '0;
                    end else begin
                        w_shadow_we = 1'b1;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            LOAD: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_load  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tmo   <= w_tmo_nxt;
            r_load  <= w_load_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_ht     <= '0;
            r_sh_ho     <= '0;
            r_sh_mt     <= '0;
            r_sh_mo     <= '0;
            r_sh_st     <= '0;
            r_hour_tens <= '0;
            r_hour_ones <= '0;
            r_min_tens  <= '0;
            r_min_ones  <= '0;
            r_sec_tens  <= '0;
            r_sec_ones  <= '0;
        end else begin
            if (w_shadow_we) begin
                case (r_idx)
                    IDX_HT:  r_sh_ht <= bus.digit[HT_W-1:0];
                    IDX_HO:  r_sh_ho <= bus.digit[HO_W-1:0];
                    IDX_MT:  r_sh_mt <= bus.digit[MT_W-1:0];
                    IDX_MO:  r_sh_mo <= bus.digit[MO_W-1:0];
                    IDX_ST:  r_sh_st <= bus.digit[ST_W-1:0];
                    default: ;
                endcase
            end
            if (w_load_nxt) begin
                r_hour_tens <= r_sh_ht;
                r_hour_ones <= r_sh_ho;
                r_min_tens  <= r_sh_mt;
                r_min_ones  <= r_sh_mo;
                r_sec_tens  <= r_sh_st;
                r_sec_ones  <= bus.digit[SO_W-1:0];
            end
        end
    end

    assign bus.digit_ready = w_ready;
    assign bus.load        = r_load;
    assign bus.err         = r_err;
    assign bus.busy        = (r_idx != '0) || (r_state == LOAD);
    assign bus.hour_tens   = r_hour_tens;
    assign bus.hour_ones   = r_hour_ones;
    assign bus.min_tens    = r_min_tens;
    assign bus.min_ones    = r_min_ones;
    assign bus.sec_tens    = r_sec_tens;
    assign bus.sec_ones    = r_sec_ones;

endmodule

`default_nettype wire

// File: doc/time_loader.md
Name: time_loader

Overview:
- Front end that sets the 24-hour clock; it is the write-side counterpart to the time display path.
- Accepts a stream of six BCD digits (HH MM SS, hour tens first) over a valid/ready handshake.
- Range-checks each digit as it arrives and, on the sixth valid digit, issues a one-cycle load strobe with the registered time fields that preset the sec/min/hour counters.
- Handles invalid digits, abort and inter-digit timeout.

Parameters:
TIMEOUT_CYC, 50_000_000, max idle cycles between accepted digits mid-sequence (1 s at 50 MHz); width of timeout counter = $clog2(TIMEOUT_CYC+1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
digit_valid  input  1  digit present on digit
digit  input  4  BCD digit value
digit_ready  output  1  block can accept a digit this cycle
abort  input  1  discard partial sequence
load  output  1  one-cycle strobe: time fields below are a new valid time
hour_tens  output  2  hour tens BCD
hour_ones  output  4  hour ones BCD
min_tens  output  3  minute tens BCD
min_ones  output  4  minute ones BCD
sec_tens  output  3  second tens BCD
sec_ones  output  4  second ones BCD
busy  output  1  partial sequence held (idx != 0) or load pending
err  output  1  one-cycle strobe: sequence rejected (bad digit or timeout)

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0, shadow regs=0, all time outputs 0 (00:00:00), load=0, err=0, busy=0, timeout counter=0.
- FSM states: IDLE, COLLECT, LOAD.
- Transitions: IDLE->COLLECT on first accept; COLLECT->LOAD on sixth accept; LOAD->IDLE unconditionally after 1 cycle.
- Handshake: digit_ready = (state != LOAD) && !abort, combinational. Accept = digit_valid && digit_ready. Digit is held by the source until accepted.
- Position checks (idx 0..5):
  - idx0 (hour tens) must be <=2.
  - idx1 (hour ones) must be <=9, and <=3 if shadow hour tens == 2.
  - idx2 (min tens) must be <=5; idx3 <=9; idx4 (sec tens) <=5; idx5 <=9.
  - Values 10..15 are always invalid.
- Valid accept: digit written to shadow[idx], idx++.
- Invalid accept: err=1 in the next cycle, idx=0, state IDLE, shadow discarded, time outputs unchanged, no load.
- Sixth valid accept at edge N:
  - At edge N+1: time outputs update from shadow, load=1 for exactly that cycle, digit_ready=0 during it.
  - Then IDLE with idx=0.
  - Latency from last accept to load = 1 cycle.
- Time outputs change only together with load; they are held between loads.
- abort=1: idx=0, state IDLE, no err, no load. Abort in the same cycle as digit_valid: abort wins and the digit is not accepted (ready=0). Abort during LOAD does not cancel the load.
- Timeout: counter clears on every accept and in IDLE. While in COLLECT, if TIMEOUT_CYC consecutive cycles pass with no accept, err=1 for one cycle and the block returns to IDLE with idx=0. An accept on the final cycle before expiry is taken normally.
- err and load are never asserted in the same cycle.
- busy = (idx != 0) || (state == LOAD).
- Reset mid-sequence: everything returns to reset values immediately, including the time outputs.

Decomposition:
- Shared package clock_pkg:
  - state enum (IDLE, COLLECT, LOAD).
  - digit index constants IDX_HT..IDX_SO.
  - range limits HOUR_TENS_MAX=2, HOUR_ONES_MAX_AT_20=3, MS_TENS_MAX=5, ONES_MAX=9.
  - Field widths shared with the cnt60/cnt24 counters.
- One natural sub-module: digit_range_chk, combinational. Inputs idx, digit, shadow hour tens; output ok.

Test Plan:
- Digits 2,3,5,9,5,9 back-to-back with valid held -> load=1 exactly 1 cycle after sixth accept, outputs 2/3/5/9/5/9, busy=0 after.
- Digits 2,4 -> err pulse the cycle after "4" is accepted, no load, outputs still 00:00:00. Then 1,9,0,0,0,0 -> load with 19:00:00.
- Digit 6 at idx2, and digit 12 at idx5 -> err each time, idx resets; a following full valid sequence loads correctly.
- 3 digits then abort; separately abort with digit_valid=1 the same cycle -> digit_ready=0, no accept, no err, no load, busy=0.
- TIMEOUT_CYC=16: 2 digits then 16 idle cycles -> err, busy=0. 2 digits, 15 idle cycles, then the rest of the sequence -> normal load.
- rst pulsed after 4 digits of 12:34 with a prior load of 23:59:59 -> outputs 0 immediately. With digit_valid held during the LOAD cycle -> digit not taken until the next cycle.
